// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial transmit controller.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/baud_tick.sv
// Baud divider: wrapping 0..CLKS_PER_BIT-1 counter with enable and synchronous
// clear; tick is a combinational flag at terminal count.
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic clr_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    // Terminal-count flag, only meaningful while counting.
    assign tick = en && (cnt_q == TERM);

    // Counter register: clear wins, then wrap at terminal count.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/serial_tx_ctrl.sv
// UART-style frame sequencer: start bit, DATA_WIDTH bits LSB first, optional
// even parity, stop bit. Define SERIAL_TX_PARITY_EN to insert the parity bit.
module serial_tx_ctrl
    import serial_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid,
    output logic                  ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BCW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  tick;
    logic                  baud_clr;
`ifdef SERIAL_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    // Counter restarts on every state change and stays parked while idle.
    assign baud_clr = (state_d != state_q) || (state_q == IDLE);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .clr_n(clr_n),
        .en   (state_q != IDLE),
        .clr  (baud_clr),
        .tick (tick)
    );

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign tx    = tx_q;
    assign done  = done_q;

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d   = START;
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d  = ^data_in;
`endif
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered, so it is derived from the values about to be loaded.
        case (state_d)
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = LINE_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any frame and idles the line.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= LINE_IDLE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Parity of the accepted word, captured at accept.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) parity_q <= 1'b0;
        else        parity_q <= parity_d;
    end
`endif

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Self-checking bench for serial_tx_ctrl (DATA_WIDTH=8, CLKS_PER_BIT=4).
// Expected line levels come from a frame model built from the bit sequence.
module tb_serial_tx_ctrl;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = DW + 3;
`else
    localparam int FRAME_BITS = DW + 2;
`endif

    logic          clk;
    logic          clr_n;
    logic [DW-1:0] data_in;
    logic          valid;
    logic          ready;
    logic          tx;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    serial_tx_ctrl #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .data_in(data_in),
        .valid  (valid),
        .ready  (ready),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Line level expected in cycle i (1 = first start-bit cycle) of a frame carrying d.
    function automatic logic model_bit(input logic [DW-1:0] d, input int i);
        int k;
        k = (i - 1) / CPB;
        if (k == 0) return 1'b0;
        if (k <= DW) return d[k-1];
`ifdef SERIAL_TX_PARITY_EN
        if (k == DW + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Idle line for n cycles: {tx,ready,busy,done} must be 1100.
    task automatic idle(input int n);
        logic [3:0] got;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            got = {tx, ready, busy, done};
            total++;
            if (got !== 4'b1100) begin
                bad++;
                $display("FAIL idle cycle %0d: {tx,ready,busy,done} got %b want 1100", c, got);
            end
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge of the done cycle.
    // hold_next keeps valid high with next_d so the next call accepts in the done cycle.
    // pulse_cycle > 0 pulses valid with 0x3C mid-frame.
    task automatic run_frame(input logic [DW-1:0] d, input bit hold_next,
                             input logic [DW-1:0] next_d, input int pulse_cycle);
        logic [3:0] got;
        logic [3:0] exp_v;
        int n;
        n = FRAME_BITS * CPB;
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready d=%02h: ready got %b want 1", d, ready);
        end
        valid   = 1'b1;
        data_in = d;
        @(posedge clk);
        #1;
        if (hold_next) data_in = next_d;
        else begin
            valid   = 1'b0;
            data_in = DW'($urandom);
        end
        for (int i = 1; i <= n + 1; i++) begin
            @(negedge clk);
            if (i <= n) exp_v = {model_bit(d, i), 1'b0, 1'b1, 1'b0};
            else        exp_v = 4'b1101;
            got = {tx, ready, busy, done};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL frame d=%02h cycle %0d: {tx,ready,busy,done} got %b want %b",
                         d, i, got, exp_v);
            end
            if (pulse_cycle > 0) begin
                if (i == pulse_cycle) begin
                    valid   = 1'b1;
                    data_in = 8'h3C;
                end else if (i == pulse_cycle + 1) begin
                    valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] got;
        clr_n = 1'b1;
        #1 clr_n = 1'b0;
        #2;
        got = {tx, ready, busy, done};
        total++;
        if (got !== 4'b1100) begin
            bad++;
            $display("FAIL reset_async: {tx,ready,busy,done} got %b want 1100", got);
        end
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single_frame();
        run_frame(8'hA5, 1'b0, 8'h00, 0);
        idle(3);
    endtask

    task automatic test_back_to_back();
        run_frame(8'h00, 1'b1, 8'hFF, 0);
        run_frame(8'hFF, 1'b0, 8'h00, 0);
        idle(3);
    endtask

    task automatic test_ignored_request();
        run_frame(8'h96, 1'b0, 8'h00, 10);
        idle(2 * FRAME_BITS * CPB);
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] got;
        logic [3:0] exp_v;
        logic [DW-1:0] d;
        d = 8'hC3;
        valid   = 1'b1;
        data_in = d;
        @(posedge clk);
        #1 valid = 1'b0;
        // Data bit 3 spans cycles 17..20; stop partway through it.
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            exp_v = {model_bit(d, i), 1'b0, 1'b1, 1'b0};
            got = {tx, ready, busy, done};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL pre_reset cycle %0d: {tx,ready,busy,done} got %b want %b",
                         i, got, exp_v);
            end
        end
        #2 clr_n = 1'b0;
        #1;
        got = {tx, ready, busy, done};
        total++;
        if (got !== 4'b1100) begin
            bad++;
            $display("FAIL reset_mid_frame: {tx,ready,busy,done} got %b want 1100", got);
        end
        @(negedge clk);
        clr_n = 1'b1;
        idle(2 * FRAME_BITS * CPB);
        run_frame(8'h5A, 1'b0, 8'h00, 0);
        idle(2);
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        logic [DW-1:0] nd;
        bit b2b;
        d = DW'($urandom);
        for (int f = 0; f < 6; f++) begin
            nd  = DW'($urandom);
            b2b = (f < 5) && ($urandom_range(0, 1) == 1);
            run_frame(d, b2b, nd, 0);
            if (!b2b) begin
                valid = 1'b0;
                idle($urandom_range(1, 4));
            end
            d = nd;
        end
        idle(2);
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity();
        run_frame(8'h07, 1'b0, 8'h00, 0);
        run_frame(8'h03, 1'b0, 8'h00, 0);
        idle(2);
    endtask
`endif

    initial begin
        clr_n   = 1'b1;
        valid   = 1'b0;
        data_in = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignored_request();
        test_reset_mid_frame();
        test_random();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
